// File: rtl/gps_sample_player.sv
// Memory-backed IF-sample playback source: streams packed multi-channel signed samples
// from a writable RAM over a programmable address window, with rate division and backpressure.
module gps_sample_player #(
  parameter int SAMPLE_W = 3,
  parameter int NUM_CH   = 1,
  parameter int DEPTH    = 1024,
  parameter int DIV_W    = 8,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int WORD_W  = NUM_CH * SAMPLE_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DIV_W-1:0]  rate_div,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [15:0]       wrap_cnt,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_loop;
  logic [ADDR_W-1:0]   r_start_addr;
  logic [ADDR_W-1:0]   r_end_addr;
  logic [DIV_W-1:0]    r_rate_div;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [1:0]          r_count;
  logic                r_head;
  logic                r_tail;
  logic [15:0]         r_wrap_cnt;
  logic [15:0]         r_stall_cnt;
  logic                r_cfg_err;

  logic [WORD_W-1:0]   r_mem       [DEPTH];
  logic [WORD_W-1:0]   r_fifo_data [2];
  logic [ADDR_W-1:0]   r_fifo_addr [2];
  logic                r_fifo_last [2];

  logic                w_tick;
  logic                w_valid;
  logic                w_pop;
  logic                w_at_end;
  logic                w_issue;
  logic                w_stall;
  logic                w_launch;
  logic                w_cfg_bad;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_tick   = (r_div_cnt == '0);
  assign w_valid  = (r_count != 2'd0);
  assign w_pop    = w_valid && out_ready;
  assign w_at_end = (r_ptr == r_end_addr);

  // Issue decision: a tick is spent only if the 2-entry FIFO has room, otherwise it is lost.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_stall     = 1'b0;
    w_launch    = 1'b0;
    w_cfg_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (end_addr < start_addr) begin
            w_cfg_bad = 1'b1;
          end else begin
            w_launch    = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_tick) begin
          if (r_count < 2'd2) w_issue = 1'b1;
          else                w_stall = 1'b1;
        end
        if (stop || (w_issue && w_at_end && !r_loop)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_count == 2'd0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_loop       <= 1'b0;
      r_start_addr <= '0;
      r_end_addr   <= '0;
      r_rate_div   <= '0;
      r_div_cnt    <= '0;
      r_ptr        <= '0;
      r_count      <= 2'd0;
      r_head       <= 1'b0;
      r_tail       <= 1'b0;
      r_wrap_cnt   <= '0;
      r_stall_cnt  <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_err <= w_cfg_bad;
      if (w_launch) begin
        r_loop       <= loop_en;
        r_start_addr <= start_addr;
        r_end_addr   <= end_addr;
        r_rate_div   <= rate_div;
        r_div_cnt    <= '0;
        r_ptr        <= start_addr;
        r_wrap_cnt   <= '0;
        r_stall_cnt  <= '0;
      end else if (r_state == S_RUN) begin
        r_div_cnt <= w_tick ? r_rate_div : r_div_cnt - 1'b1;
      end
      if (w_issue) begin
        r_tail <= ~r_tail;
        if (!w_at_end) begin
          r_ptr <= r_ptr + 1'b1;
        end else if (r_loop) begin
          r_ptr      <= r_start_addr;
          r_wrap_cnt <= sat_inc(r_wrap_cnt);
        end
      end
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_pop)   r_head      <= ~r_head;
      r_count <= r_count + {1'b0, w_issue} - {1'b0, w_pop};
    end
  end

  // Synchronous RAM; the read lands directly in the FIFO slot, giving one cycle of latency.
  always_ff @(posedge CLK) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (w_issue) begin
      r_fifo_data[r_tail] <= r_mem[r_ptr];
      r_fifo_addr[r_tail] <= r_ptr;
      r_fifo_last[r_tail] <= w_at_end && !r_loop;
    end
  end

  assign out_valid = w_valid;
  assign out_data  = w_valid ? r_fifo_data[r_head] : '0;
  assign out_addr  = w_valid ? r_fifo_addr[r_head] : '0;
  assign out_last  = w_valid && r_fifo_last[r_head];
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DRAIN) && (r_count == 2'd0);
  assign cfg_err   = r_cfg_err;
  assign wrap_cnt  = r_wrap_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_gps_sample_player.sv
// Bench for gps_sample_player: queue-based playback model checked every cycle,
// plus directed scenarios with hand-computed expectations and randomized runs.
`timescale 1ns/1ps
module tb_gps_sample_player;
  localparam int ADDR_W = 10;
  localparam int WORD_W = 3;
  localparam int DIV_W  = 8;
  localparam int DEPTH  = 1024;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic [DIV_W-1:0]  rate_div = '0;
  logic              out_ready = 1'b0;
  logic              out_valid, out_last, busy, done, cfg_err;
  logic [WORD_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic [15:0]       wrap_cnt, stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  gps_sample_player dut (
    .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en), .start_addr(start_addr),
    .end_addr(end_addr), .rate_div(rate_div), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last), .busy(busy),
    .done(done), .cfg_err(cfg_err), .wrap_cnt(wrap_cnt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, a word queue standing in for the FIFO, and tick = RUN-cycle index mod (div+1).
  typedef struct { int data; int addr; bit last; } word_t;
  word_t m_q[$];
  int    m_mem [DEPTH];
  int    m_mode = 0;
  int    m_ptr, m_sa, m_ea, m_div, m_runcyc;
  int    m_wrap = 0, m_stall = 0;
  bit    m_loop, m_cfg = 1'b0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_mode = 0; m_q.delete(); m_wrap = 0; m_stall = 0; m_cfg = 1'b0;
    end else begin
      bit pop, iss, cfg;
      word_t w;
      pop = (m_q.size() > 0) && out_ready;
      iss = 1'b0; cfg = 1'b0;
      w.data = 0; w.addr = 0; w.last = 1'b0;
      case (m_mode)
        0: if (start) begin
          if (int'(end_addr) < int'(start_addr)) cfg = 1'b1;
          else begin
            m_sa = int'(start_addr); m_ea = int'(end_addr); m_loop = loop_en;
            m_div = int'(rate_div); m_ptr = m_sa; m_runcyc = 0;
            m_wrap = 0; m_stall = 0; m_mode = 1;
          end
        end
        1: begin
          if ((m_runcyc % (m_div + 1)) == 0) begin
            if (m_q.size() < 2) begin
              iss = 1'b1;
              w.data = m_mem[m_ptr]; w.addr = m_ptr; w.last = (m_ptr == m_ea) && !m_loop;
              if (m_ptr != m_ea) m_ptr++;
              else if (m_loop) begin
                m_ptr = m_sa;
                if (m_wrap < 65535) m_wrap++;
              end
            end else if (m_stall < 65535) m_stall++;
          end
          m_runcyc++;
          if (stop || (iss && w.last)) m_mode = 2;
        end
        default: if (m_q.size() == 0) m_mode = 0;
      endcase
      if (pop) void'(m_q.pop_front());
      if (iss) m_q.push_back(w);
      if (wr_en) m_mem[int'(wr_addr)] = int'(wr_data);
      m_cfg = cfg;
    end
  end

  always @(negedge CLK) begin
    chk("valid", out_valid, m_q.size() > 0);
    chk("busy", busy, m_mode != 0);
    chk("done", done, (m_mode == 2) && (m_q.size() == 0));
    chk("cfg_err", cfg_err, m_cfg);
    chk("wrap_cnt", wrap_cnt, m_wrap);
    chk("stall_cnt", stall_cnt, m_stall);
    if (m_q.size() > 0) begin
      chk("data", out_data, m_q[0].data);
      chk("addr", out_addr, m_q[0].addr);
      chk("last", out_last, m_q[0].last);
    end else if (!RST_N) begin
      chk("rst_data", out_data, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_last", out_last, 0);
    end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic start_run(input int sa, input int ea, input bit lp, input int dv);
    start_addr = ADDR_W'(sa); end_addr = ADDR_W'(ea); loop_en = lp; rate_div = DIV_W'(dv);
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      cyc();
    end
    chk({nm, "_idle_timeout"}, ok, 1);
  endtask

  // One-shot window inside the k mod 8 preload region, rate_div=0, ready held high.
  task automatic oneshot_check(input string nm, input int sa, input int ea);
    out_ready = 1'b1;
    start_run(sa, ea, 1'b0, 0);
    chk({nm, "_busy_c1"}, busy, 1);
    chk({nm, "_valid_c1"}, out_valid, 0);
    cyc();
    for (int k = sa; k <= ea; k++) begin
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_data"}, out_data, k % 8);
      chk({nm, "_addr"}, out_addr, k);
      chk({nm, "_last"}, out_last, k == ea);
      cyc();
    end
    chk({nm, "_valid_after"}, out_valid, 0);
    chk({nm, "_done"}, done, 1);
    cyc();
    chk({nm, "_done_off"}, done, 0);
    chk({nm, "_busy_off"}, busy, 0);
    chk({nm, "_stall"}, stall_cnt, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra, npop;
    bit seen;
    int pa[$];
    int pd[$];

    repeat (3) cyc();
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_wrap", wrap_cnt, 0);
    RST_N = 1'b1;
    cyc();

    for (int k = 0; k < 64; k++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(k);
      wr_data = (k < 16) ? WORD_W'(k % 8) : WORD_W'($urandom);
      cyc();
    end
    wr_en = 1'b0;

    oneshot_check("s1", 2, 5);

    out_ready = 1'b1;
    start_run(2, 5, 1'b1, 0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("s2_valid", out_valid, 1);
      chk("s2_data", out_data, 2 + (i % 4));
      if (i == 9) stop = 1'b1;
      cyc();
    end
    stop = 1'b0;
    chk("s2_wrap", wrap_cnt, 2);
    extra = 0; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        extra++;
        chk("s2_no_last", out_last, 0);
      end
      if (done) begin seen = 1'b1; break; end
      cyc();
    end
    chk("s2_extra_le2", extra <= 2, 1);
    chk("s2_done_seen", seen, 1);
    wait_idle("s2");

    start_run(0, 3, 1'b0, 3);
    for (int c = 1; c <= 15; c++) begin
      bit ev;
      ev = (c >= 2) && (c <= 14) && (((c - 2) % 4) == 0);
      chk("s3_valid", out_valid, ev);
      if (ev) begin
        chk("s3_data", out_data, (c - 2) / 4);
        chk("s3_last", out_last, c == 14);
      end
      if (c == 15) chk("s3_done", done, 1);
      cyc();
    end
    wait_idle("s3");

    start_run(0, 15, 1'b0, 0);
    seen = 1'b0;
    for (int c = 1; c < 200; c++) begin
      if (c == 4)  out_ready = 1'b0;
      if (c == 14) out_ready = 1'b1;
      if (c >= 5 && c <= 13) chk("s4_hold", out_data, 2);
      if (out_valid && out_ready) begin
        pa.push_back(int'(out_addr)); pd.push_back(int'(out_data));
      end
      if (done) begin seen = 1'b1; break; end
      cyc();
    end
    chk("s4_done_seen", seen, 1);
    npop = pa.size();
    chk("s4_words", npop, 16);
    for (int i = 0; i < npop && i < 16; i++) begin
      chk("s4_seq_addr", pa[i], i);
      chk("s4_seq_data", pd[i], i % 8);
    end
    chk("s4_stall", stall_cnt, 10);
    wait_idle("s4");

    start_run(9, 4, 1'b0, 0);
    chk("s5_cfg_err", cfg_err, 1);
    chk("s5_busy", busy, 0);
    cyc();
    chk("s5_cfg_err_off", cfg_err, 0);
    chk("s5_busy2", busy, 0);
    chk("s5_valid", out_valid, 0);

    start_run(2, 5, 1'b1, 0);
    repeat (3) cyc();
    RST_N = 1'b0;
    #1;
    chk("s6_valid", out_valid, 0);
    chk("s6_busy", busy, 0);
    chk("s6_data", out_data, 0);
    chk("s6_done", done, 0);
    repeat (3) begin
      cyc();
      chk("s6_no_done", done, 0);
    end
    RST_N = 1'b1;
    cyc();
    oneshot_check("s6_replay", 2, 5);

    for (int r = 0; r < 30; r++) begin
      int sa, ea, lim;
      bit lp, fin;
      sa = $urandom_range(0, 63);
      ea = (($urandom % 8) == 0) ? $urandom_range(0, 63) : $urandom_range(sa, 63);
      lp = $urandom_range(0, 1);
      lim = $urandom_range(5, 120);
      start_run(sa, ea, lp, $urandom_range(0, 3));
      fin = 1'b0;
      for (int c = 1; c < 3000; c++) begin
        if (!busy) begin fin = 1'b1; break; end
        out_ready = ($urandom % 4) != 0;
        wr_en = ($urandom % 8) == 0;
        wr_addr = ADDR_W'($urandom_range(0, 63));
        wr_data = WORD_W'($urandom);
        start = ($urandom % 16) == 0;
        stop = (lp && c >= lim) || (($urandom % 100) == 0);
        cyc();
      end
      chk("rand_finished", fin, 1);
      wr_en = 1'b0; start = 1'b0;
      stop = 1'b1; cyc(); stop = 1'b0;
      out_ready = 1'b1;
      cyc();
    end

    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
